// File: rtl/sync_asr_repeater.sv
// Reset / debug-init repeater: a STAGES-deep synchronizer that brings an
// asynchronous level into the gclk domain. It has an asynchronous active-high
// reset and a scan shift path muxed in front of the first stage.
// Optional feature (macro SYNC_CKEN_EN): a clock-enable synchronizer, made of
// a rising-edge capture flop followed by a falling-edge lock-up stage, so that
// gclk & cken_sync is glitch-free.
// STAGES must lie in 2..8.
module sync_asr_repeater #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic gclk,
  input  logic arst,
  input  logic async_in,
  input  logic si,
  input  logic se,
`ifdef SYNC_CKEN_EN
  input  logic cken,
  output logic cken_sync,
`endif
  output logic sync_out,
  output logic so
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  // Select the stage-0 source per edge (scan or function) and shift toward the output.
  // Only stage 1 reads stage 0, so a metastable sample settles before it is used.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], (se ? si : async_in)};
  end

  // Synchronizer chain. Reset is asynchronous, so it takes effect with no clock edge.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      stage_q <= {STAGES{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  // The functional output and the scan output are the same physical stage.
  always_comb begin
    sync_out = stage_q[STAGES-1];
    so       = stage_q[STAGES-1];
  end

`ifdef SYNC_CKEN_EN
  logic cken_m_q;
  logic cken_sync_q;

  // Capture the raw enable on the rising edge. This path is kept off the scan chain.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      cken_m_q <= 1'b0;
    end else begin
      cken_m_q <= cken;
    end
  end

  // Lock-up stage: it updates only while gclk is low, so the gated clock cannot glitch.
  always_ff @(negedge gclk or posedge arst) begin
    if (arst) begin
      cken_sync_q <= 1'b0;
    end else begin
      cken_sync_q <= cken_m_q;
    end
  end

  // Drive the synchronized enable output from the lock-up stage.
  always_comb begin
    cken_sync = cken_sync_q;
  end
`endif

endmodule

// File: tb/tb_sync_asr_repeater.sv
// Self-checking bench for sync_asr_repeater. It drives two instances in
// parallel, one with STAGES=2 and one with STAGES=4. The reference model keeps
// the history of values sampled since the last reset. The expected output is
// the sample taken STAGES-1 edges earlier, or RST_VAL if there is no such
// sample yet.
module tb_sync_asr_repeater;

  logic gclk = 1'b0;
  logic arst = 1'b0;
  logic async_in = 1'b0;
  logic si = 1'b0;
  logic se = 1'b0;
  logic sync_out2, so2, sync_out4, so4;
`ifdef SYNC_CKEN_EN
  logic cken = 1'b0;
  logic cken_sync2, cken_sync4;
  logic ck_m_exp = 1'b0;
  logic ck_sync_exp = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic hist[$];

  sync_asr_repeater #(.STAGES(2), .RST_VAL(1'b0)) dut2 (
    .gclk(gclk), .arst(arst), .async_in(async_in), .si(si), .se(se),
`ifdef SYNC_CKEN_EN
    .cken(cken), .cken_sync(cken_sync2),
`endif
    .sync_out(sync_out2), .so(so2)
  );

  sync_asr_repeater #(.STAGES(4), .RST_VAL(1'b0)) dut4 (
    .gclk(gclk), .arst(arst), .async_in(async_in), .si(si), .se(se),
`ifdef SYNC_CKEN_EN
    .cken(cken), .cken_sync(cken_sync4),
`endif
    .sync_out(sync_out4), .so(so4)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic model_out(input int st);
    if (hist.size() >= st) return hist[hist.size() - st];
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_out2"}, sync_out2, model_out(2));
    check({tag, "_so2"}, so2, model_out(2));
    check({tag, "_out4"}, sync_out4, model_out(4));
    check({tag, "_so4"}, so4, model_out(4));
  endtask

  task automatic reset_model();
    hist.delete();
`ifdef SYNC_CKEN_EN
    ck_m_exp = 1'b0;
    ck_sync_exp = 1'b0;
`endif
  endtask

  // One full gclk period. Inputs are changed by the caller only while gclk is low.
  task automatic tick(input string tag);
    logic smp;
    smp = se ? si : async_in;
    gclk = 1'b1;
    if (arst) reset_model();
    else begin
      hist.push_back(smp);
`ifdef SYNC_CKEN_EN
      ck_m_exp = cken;
`endif
    end
    #2;
    check_all(tag);
`ifdef SYNC_CKEN_EN
    // cken_sync must not move while gclk is high.
    check({tag, "_ckhi2"}, cken_sync2, ck_sync_exp);
    check({tag, "_ckhi4"}, cken_sync4, ck_sync_exp);
`endif
    #3;
    gclk = 1'b0;
`ifdef SYNC_CKEN_EN
    if (!arst) ck_sync_exp = ck_m_exp;
    #1;
    check({tag, "_cklo2"}, cken_sync2, ck_sync_exp);
    check({tag, "_cklo4"}, cken_sync4, ck_sync_exp);
    #4;
`else
    #5;
`endif
  endtask

  // Pulse reset without a clock edge and confirm that the clear is immediate.
  task automatic pulse_arst(input string tag);
    arst = 1'b1;
    reset_model();
    #1;
    check_all({tag, "_imm"});
    #1;
    arst = 1'b0;
    #1;
    check_all({tag, "_rel"});
  endtask

  int first_hi;
  int width;

  initial begin
    // Reset with gclk stopped and async_in high: the outputs clear at once.
    async_in = 1'b1;
    #3;
    arst = 1'b1;
    reset_model();
    #1;
    check_all("arst_noclk");
    for (int i = 0; i < 3; i++) tick("arst_hold");
    // Release between edges: the outputs hold RST_VAL until the next edge.
    async_in = 1'b0;
    #1;
    arst = 1'b0;
    #1;
    check_all("arst_release");

    // Latency: async_in rises before edge k.
    for (int i = 0; i < 4; i++) tick("lat_pre");
    async_in = 1'b1;
    tick("lat_k");
    check("lat_k_s2_low", sync_out2, 1'b0);
    tick("lat_k1");
    check("lat_k1_s2_high", sync_out2, 1'b1);
    async_in = 1'b0;
    for (int i = 0; i < 5; i++) tick("lat_post");

    // STAGES=4: a pulse 3 cycles wide keeps its width and arrives 3 edges late.
    first_hi = -1;
    width = 0;
    for (int t = 0; t < 10; t++) begin
      async_in = (t < 3);
      tick("pulse4");
      if (sync_out4) begin
        width++;
        if (first_hi < 0) first_hi = t;
      end
    end
    check("pulse4_width_eq3", (width == 3), 1'b1);
    check("pulse4_first_at3", (first_hi == 3), 1'b1);

    // Random functional stimulus.
    for (int i = 0; i < 60; i++) begin
      async_in = 1'($urandom);
      tick("rand_func");
    end

    // Scan: shift 1,0,1,1 while async_in toggles randomly.
    se = 1'b1;
    for (int i = 0; i < 4; i++) begin
      si = (i == 1) ? 1'b0 : 1'b1;
      async_in = 1'($urandom);
      tick("scan_pat");
    end
    si = 1'b0;
    tick("scan_tail0");
    tick("scan_tail1");

    // Reset during scan with state 11, then load from si on the next edge.
    si = 1'b1;
    tick("scan_fill0");
    tick("scan_fill1");
    check("scan_state11", so2, 1'b1);
    pulse_arst("scan_arst");
    si = 1'b1;
    tick("scan_after_arst");

    // Random mix with se changing from edge to edge.
    for (int i = 0; i < 60; i++) begin
      se = 1'($urandom);
      si = 1'($urandom);
      async_in = 1'($urandom);
`ifdef SYNC_CKEN_EN
      cken = 1'($urandom);
`endif
      tick("rand_mix");
      if (i == 30) pulse_arst("mix_arst");
    end

`ifdef SYNC_CKEN_EN
    // Clock-enable path: rises at the falling edge after the capture edge.
    cken = 1'b0;
    tick("ck_pre0");
    tick("ck_pre1");
    cken = 1'b1;
    tick("ck_rise");
    check("ck_rise_after_fall", cken_sync2, 1'b1);
    tick("ck_steady");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
